// File: rtl/clk_div_pkg.sv
// Shared definitions for the rate-controlled clock divider: controller states,
// the smallest legal divide ratio and the ratio loaded out of reset.
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  localparam int MIN_DIV       = 2;
  localparam int DEFAULT_DIV_C = 125;

endpackage

// File: rtl/div_period_counter.sv
// Period counter for the divider: counts 0..div_i-1 while run_i is high and
// reports the terminal count, the first count and the high-phase half.
module div_period_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic [WIDTH-1:0] div_i,
  output logic             tc_o,
  output logic             zero_o,
  output logic             phase_hi_o
);

  logic [WIDTH-1:0] count;
  logic [WIDTH:0]   low_len;

  // ceil(N/2) low cycles; the extra bit keeps N+1 from overflowing at the top ratio
  assign low_len    = ({1'b0, div_i} + (WIDTH + 1)'(1)) >> 1;
  assign phase_hi_o = ({1'b0, count} >= low_len);
  assign tc_o       = (count == (div_i - WIDTH'(1)));
  assign zero_o     = (count == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i || !run_i || tc_o) begin
      count <= '0;
    end else begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/rate_clk_ctrl.sv
// Divided-clock generator whose ratio can be changed on the fly; a new ratio
// only ever takes effect on a period boundary, so no phase is ever truncated.
module rate_clk_ctrl
  import clk_div_pkg::*;
#(
  parameter int COUNTER_WIDTH = 8,
  parameter int DEFAULT_DIV   = DEFAULT_DIV_C
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic [COUNTER_WIDTH-1:0] cfg_div_i,
  input  logic                     cfg_req_i,
  output logic                     cfg_ack_o,
  output logic                     cfg_err_o,
  output logic                     clk_o,
  output logic                     tick_o,
  output logic                     busy_o,
  output logic [COUNTER_WIDTH-1:0] div_o
);

  localparam logic [COUNTER_WIDTH-1:0] DIV_RST = COUNTER_WIDTH'(DEFAULT_DIV);
  localparam logic [COUNTER_WIDTH-1:0] DIV_MIN = COUNTER_WIDTH'(MIN_DIV);

  state_t                   state;
  logic [COUNTER_WIDTH-1:0] div_reg;
  logic [COUNTER_WIDTH-1:0] pend_div;
  logic                     req_ok;
  logic                     req_bad;
  logic                     tc;
  logic                     at_zero;
  logic                     phase_hi;

  // cfg_req_i is a one-cycle strobe with no back-pressure: every strobe is
  // answered by exactly one cfg_err_o, or folded into the next cfg_ack_o.
  assign req_ok  = cfg_req_i && (cfg_div_i >= DIV_MIN);
  assign req_bad = cfg_req_i && (cfg_div_i < DIV_MIN);
  assign busy_o  = (state != ST_IDLE);
  assign div_o   = div_reg;

  div_period_counter #(
    .WIDTH(COUNTER_WIDTH)
  ) u_period (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .run_i     (busy_o),
    .div_i     (div_reg),
    .tc_o      (tc),
    .zero_o    (at_zero),
    .phase_hi_o(phase_hi)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      div_reg   <= DIV_RST;
      pend_div  <= DIV_RST;
      cfg_ack_o <= 1'b0;
      cfg_err_o <= 1'b0;
      clk_o     <= 1'b0;
      tick_o    <= 1'b0;
    end else begin
      cfg_ack_o <= 1'b0;
      cfg_err_o <= req_bad;
      clk_o     <= busy_o && phase_hi;
      tick_o    <= busy_o && at_zero;

      case (state)
        ST_IDLE: begin
          if (req_ok) begin
            div_reg   <= cfg_div_i;
            cfg_ack_o <= 1'b1;
          end
          if (enable_i) begin
            state <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (tc) begin
            if (req_ok) begin
              div_reg   <= cfg_div_i;
              cfg_ack_o <= 1'b1;
            end
            state <= enable_i ? ST_RUN : ST_IDLE;
          end else if (req_ok) begin
            pend_div <= cfg_div_i;
            state    <= ST_PEND;
          end
        end

        ST_PEND: begin
          // A request landing on the boundary itself is the newest, so it wins
          if (tc) begin
            div_reg   <= req_ok ? cfg_div_i : pend_div;
            cfg_ack_o <= 1'b1;
            state     <= enable_i ? ST_RUN : ST_IDLE;
          end else if (req_ok) begin
            pend_div <= cfg_div_i;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rate_clk_ctrl.sv
// Self-checking bench for rate_clk_ctrl: IDLE config vector table, directed
// multi-cycle sequences, and randomized traffic against a period-level model.
module tb_rate_clk_ctrl;

  localparam int W   = 8;
  localparam int DEF = 125;

  logic         clk_i;
  logic         rst_i;
  logic         enable_i;
  logic [W-1:0] cfg_div_i;
  logic         cfg_req_i;
  logic         cfg_ack_o;
  logic         cfg_err_o;
  logic         clk_o;
  logic         tick_o;
  logic         busy_o;
  logic [W-1:0] div_o;

  int n_vec   = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int ack_cnt = 0;
  int err_cnt = 0;
  bit chk_en  = 1'b0;

  // reference model: on/off, optional pending ratio, position within the period
  bit m_on, m_pend;
  int m_n, m_pn, m_pos;
  bit e_clk, e_tick, e_ack, e_err;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] div;
    logic         req;
    logic         ack;
    logic         err;
    logic [W-1:0] dv;
  } vec_t;
  vec_t tbl[8];

  rate_clk_ctrl #(
    .COUNTER_WIDTH(W),
    .DEFAULT_DIV  (DEF)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .cfg_div_i(cfg_div_i),
    .cfg_req_i(cfg_req_i),
    .cfg_ack_o(cfg_ack_o),
    .cfg_err_o(cfg_err_o),
    .clk_o    (clk_o),
    .tick_o   (tick_o),
    .busy_o   (busy_o),
    .div_o    (div_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
    cyc++;
    if (cfg_ack_o === 1'b1) ack_cnt++;
    if (cfg_err_o === 1'b1) err_cnt++;
  endtask

  task automatic drive_req(input int div);
    cfg_div_i = W'(div);
    cfg_req_i = 1'b1;
    step();
    cfg_req_i = 1'b0;
  endtask

  task automatic wait_tick(input string name, input int budget);
    int i;
    i = 0;
    do begin
      step();
      i++;
    end while (tick_o !== 1'b1 && i < budget);
    check({name, " tick seen"}, tick_o, 1);
  endtask

  // Called on a tick cycle: walks one full period and measures both phases.
  task automatic measure(input string name, input int exp_lo, input int exp_hi);
    int lo, hi;
    lo = 0;
    hi = 0;
    while (clk_o === 1'b0 && lo < 400) begin
      lo++;
      step();
    end
    while (clk_o === 1'b1 && hi < 400) begin
      hi++;
      step();
    end
    check({name, " low phase"}, lo, exp_lo);
    check({name, " high phase"}, hi, exp_hi);
    check({name, " tick at period start"}, tick_o, 1);
  endtask

  // ---------------- reference model ----------------
  task automatic model_step();
    bit ok;
    if (rst_i) begin
      m_on = 0; m_pend = 0; m_n = DEF; m_pn = DEF; m_pos = 0;
      e_clk = 0; e_tick = 0; e_ack = 0; e_err = 0;
      return;
    end
    ok     = cfg_req_i && (int'(cfg_div_i) >= 2);
    e_err  = cfg_req_i && (int'(cfg_div_i) < 2);
    e_ack  = 0;
    e_clk  = m_on && (2 * m_pos >= m_n);
    e_tick = m_on && (m_pos == 0);
    if (!m_on) begin
      if (ok) begin
        m_n   = int'(cfg_div_i);
        e_ack = 1;
      end
      m_on  = enable_i;
      m_pos = 0;
    end else begin
      if (ok) begin
        m_pn   = int'(cfg_div_i);
        m_pend = 1;
      end
      if (m_pos == m_n - 1) begin
        if (m_pend) begin
          m_n    = m_pn;
          m_pend = 0;
          e_ack  = 1;
        end
        m_pos = 0;
        m_on  = enable_i;
      end else begin
        m_pos++;
      end
    end
    if (e_ack) exp_q.push_back(W'(m_n));
  endtask

  initial forever begin
    @(posedge clk_i);
    model_step();
  end

  // ---------------- scoreboard ----------------
  initial forever begin
    @(negedge clk_i);
    if (chk_en) begin
      check("model clk_o", clk_o, e_clk);
      check("model tick_o", tick_o, e_tick);
      check("model cfg_ack_o", cfg_ack_o, e_ack);
      check("model cfg_err_o", cfg_err_o, e_err);
      check("model busy_o", busy_o, m_on);
      check("model div_o", div_o, m_n);
      if (cfg_ack_o === 1'b1) begin
        if (exp_q.size() == 0) check("ack without expected ratio", 1, 0);
        else check("ratio at ack", div_o, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int t0, a0, e0, cnt_tick, cnt_hi, i;

    tbl[0] = '{8'd0,   1'b1, 1'b0, 1'b1, 8'd125};
    tbl[1] = '{8'd1,   1'b1, 1'b0, 1'b1, 8'd125};
    tbl[2] = '{8'd2,   1'b1, 1'b1, 1'b0, 8'd2};
    tbl[3] = '{8'd200, 1'b1, 1'b1, 1'b0, 8'd200};
    tbl[4] = '{8'd7,   1'b0, 1'b0, 1'b0, 8'd200};
    tbl[5] = '{8'd255, 1'b1, 1'b1, 1'b0, 8'd255};
    tbl[6] = '{8'd1,   1'b1, 1'b0, 1'b1, 8'd255};
    tbl[7] = '{8'd125, 1'b1, 1'b1, 1'b0, 8'd125};

    rst_i = 1'b1; enable_i = 1'b0; cfg_req_i = 1'b0; cfg_div_i = '0;
    repeat (3) step();
    chk_en = 1'b1;
    check("reset busy_o", busy_o, 0);
    check("reset div_o", div_o, DEF);
    check("reset clk_o", clk_o, 0);
    check("reset tick_o", tick_o, 0);
    check("reset cfg_ack_o", cfg_ack_o, 0);
    rst_i = 1'b0;
    step();
    check("first cycle after release pulses", {cfg_ack_o, cfg_err_o, tick_o}, 0);

    // IDLE configuration table
    for (int k = 0; k < 8; k++) begin
      cfg_div_i = tbl[k].div;
      cfg_req_i = tbl[k].req;
      step();
      cfg_req_i = 1'b0;
      check($sformatf("table[%0d] ack", k), cfg_ack_o, tbl[k].ack);
      check($sformatf("table[%0d] err", k), cfg_err_o, tbl[k].err);
      check($sformatf("table[%0d] div_o", k), div_o, tbl[k].dv);
      step();
      check($sformatf("table[%0d] pulse width", k), {cfg_ack_o, cfg_err_o}, 0);
    end

    // N=125 run: low 63, high 62
    enable_i = 1'b1;
    wait_tick("start", 10);
    check("busy while running", busy_o, 1);
    measure("n125", 63, 62);

    // request 10 at count 40: current period still ends at 125
    t0 = cyc;
    repeat (39) step();
    a0 = ack_cnt;
    drive_req(10);
    wait_tick("n125->10", 200);
    check("n125->10 period length", cyc - t0, 125);
    check("n125->10 ack count", ack_cnt - a0, 1);
    check("n125->10 div_o", div_o, 10);
    measure("n10", 5, 5);

    // 10 then 7 inside one period: a single ack, new period 7
    a0 = ack_cnt;
    drive_req(10);
    drive_req(7);
    wait_tick("batch", 20);
    check("batch ack count", ack_cnt - a0, 1);
    check("batch div_o", div_o, 7);
    measure("n7", 4, 3);
    check("batch ack count after period", ack_cnt - a0, 1);

    // invalid ratios are rejected without disturbing the clock
    a0 = ack_cnt;
    e0 = err_cnt;
    drive_req(1);
    drive_req(0);
    step();
    check("invalid err count", err_cnt - e0, 2);
    check("invalid ack count", ack_cnt - a0, 0);
    check("invalid div_o", div_o, 7);
    wait_tick("invalid", 20);
    measure("n7 after invalid", 4, 3);

    // back to 125, then drop enable at count 20
    drive_req(125);
    wait_tick("to n125", 20);
    check("to n125 div_o", div_o, 125);
    t0 = cyc;
    repeat (19) step();
    enable_i = 1'b0;
    i = 0;
    while (busy_o === 1'b1 && i < 300) begin
      step();
      i++;
    end
    check("stop busy_o", busy_o, 0);
    check("stop after count 124", cyc - t0, 124);
    step();
    check("stop clk_o low", clk_o, 0);
    cnt_tick = 0;
    cnt_hi = 0;
    repeat (20) begin
      step();
      if (tick_o === 1'b1) cnt_tick++;
      if (clk_o !== 1'b0) cnt_hi++;
    end
    check("idle tick count", cnt_tick, 0);
    check("idle clk_o high count", cnt_hi, 0);

    // drop and re-raise enable inside one period: no interruption
    enable_i = 1'b1;
    wait_tick("restart", 10);
    t0 = cyc;
    repeat (19) step();
    enable_i = 1'b0;
    repeat (10) step();
    enable_i = 1'b1;
    wait_tick("reassert", 200);
    check("reassert period length", cyc - t0, 125);
    check("reassert busy_o", busy_o, 1);

    // reset at count 50 with a change pending
    a0 = ack_cnt;
    drive_req(10);
    repeat (48) step();
    rst_i = 1'b1;
    enable_i = 1'b0;
    step();
    check("mid reset busy_o", busy_o, 0);
    check("mid reset div_o", div_o, 125);
    check("mid reset clk_o", clk_o, 0);
    rst_i = 1'b0;
    step();
    check("mid reset release pulses", {cfg_ack_o, cfg_err_o, tick_o}, 0);
    repeat (150) step();
    check("mid reset ack count", ack_cnt - a0, 0);
    check("mid reset final div_o", div_o, 125);
    check("mid reset final busy_o", busy_o, 0);

    // randomized traffic, checked cycle by cycle against the model
    enable_i = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      rst_i = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 99) < 2) enable_i = ~enable_i;
      cfg_req_i = ($urandom_range(0, 9) == 0);
      cfg_div_i = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : W'($urandom_range(0, 14));
      step();
    end
    rst_i = 1'b0;
    cfg_req_i = 1'b0;
    repeat (5) step();
    check("scoreboard queue drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
